// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Galois LFSR with enable, load, lock-up recovery and period tracking
// Ports: clk/reset (sync, active-high); en steps the LFSR; load writes load_val (beats en);
//        q is the state; wrap pulses when a step lands back on SEED; lockup pulses when an
//        all-zero state is replaced by SEED; step_cnt counts steps since reset/load/wrap;
//        period holds the length of the last completed cycle (0 until the first wrap).
module lfsr_gen #(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] TAPS  = 5'h14,
  parameter logic [WIDTH-1:0] SEED  = 5'h01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             lockup,
  output logic [WIDTH-1:0] step_cnt,
  output logic [WIDTH-1:0] period
);
  logic [WIDTH-1:0] q_q, q_d, step_q, step_d, period_q, period_d, nxt, step_inc;
  logic             wrap_q, wrap_d, lockup_q, lockup_d, zero, adv;
  always_comb begin
    nxt      = (q_q >> 1) ^ (q_q[0] ? TAPS : '0);
    step_inc = step_q + 1'b1;
    zero     = q_q == '0;
    adv      = en & ~load;
    wrap_d   = adv & ~zero & (nxt == SEED);
    lockup_d = adv & zero;
    q_d      = load ? load_val : en ? (zero ? SEED : nxt) : q_q;
    step_d   = (load | lockup_d | wrap_d) ? '0 : en ? step_inc : step_q;
    period_d = wrap_d ? step_inc : period_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q      <= SEED;
      step_q   <= '0;
      period_q <= '0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      step_q   <= step_d;
      period_q <= period_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end
  assign q        = q_q;
  assign wrap     = wrap_q;
  assign lockup   = lockup_q;
  assign step_cnt = step_q;
  assign period   = period_q;
endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: self-checking bench for lfsr_gen at 5-bit defaults and an 8-bit maximal configuration
module tb_lfsr_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       r5, en5, ld5, w5, lk5;
  logic [4:0] lv5, q5, sc5, pr5;
  logic       r8, en8, ld8, w8, lk8;
  logic [7:0] lv8, q8, sc8, pr8;
  int checks = 0, fails = 0;
  int mq = 1, mstep = 0, mper = 0;
  bit mwrap = 0, mlock = 0;
  lfsr_gen d5 (
    .clk(clk), .reset(r5), .en(en5), .load(ld5), .load_val(lv5),
    .q(q5), .wrap(w5), .lockup(lk5), .step_cnt(sc5), .period(pr5)
  );
  lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01)) d8 (
    .clk(clk), .reset(r8), .en(en8), .load(ld8), .load_val(lv8),
    .q(q8), .wrap(w8), .lockup(lk8), .step_cnt(sc8), .period(pr8)
  );
  function automatic int galois(int s, int taps);
    return (s / 2) ^ ((s % 2 == 1) ? taps : 0);
  endfunction
  task automatic cyc5(bit r, bit l, bit e, logic [4:0] v);
    int n;
    r5 = r; ld5 = l; en5 = e; lv5 = v;
    @(posedge clk); #1;
    mwrap = 0; mlock = 0;
    if (r) begin
      mq = 1; mstep = 0; mper = 0;
    end else if (l) begin
      mq = int'(v); mstep = 0;
    end else if (e && mq == 0) begin
      mq = 1; mlock = 1; mstep = 0;
    end else if (e) begin
      n = galois(mq, 'h14);
      if (n == 1) begin
        mwrap = 1; mper = (mstep + 1) % 32; mstep = 0;
      end else mstep = (mstep + 1) % 32;
      mq = n;
    end
  endtask
  task automatic test_reset;
    cyc5(1, 0, 1, 5'h1f);
    checks++;
    if ({q5, w5, lk5, sc5, pr5} !== {5'h01, 1'b0, 1'b0, 5'h00, 5'h00}) begin
      fails++;
      $display("FAIL reset: q=%h wrap=%b lockup=%b step=%0d period=%0d, want q=01 0 0 0 0", q5, w5, lk5, sc5, pr5);
    end
  endtask
  task automatic test_first_steps;
    logic [4:0] exp [5] = '{5'b10100, 5'b01010, 5'b00101, 5'b10110, 5'b01011};
    cyc5(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc5(0, 0, 1, 0);
      checks++;
      if (q5 !== exp[i] || w5 !== 1'b0) begin
        fails++;
        $display("FAIL first_step%0d: q=%b wrap=%b, want q=%b wrap=0", i, q5, w5, exp[i]);
      end
    end
    checks++;
    if (sc5 !== 5'd5) begin
      fails++;
      $display("FAIL first_steps_cnt: step=%0d want 5", sc5);
    end
  endtask
  task automatic test_full_period;
    bit [31:0] seen = 0;
    cyc5(1, 0, 0, 0);
    for (int i = 1; i <= 31; i++) begin
      cyc5(0, 0, 1, 0);
      seen[q5] = 1'b1;
      checks++;
      if (i < 31 && (w5 !== 1'b0 || q5 !== 5'(mq))) begin
        fails++;
        $display("FAIL period_walk%0d: q=%h wrap=%b, want q=%h wrap=0", i, q5, w5, mq);
      end
    end
    checks++;
    if ({q5, w5, pr5, sc5} !== {5'h01, 1'b1, 5'd31, 5'd0}) begin
      fails++;
      $display("FAIL period_wrap: q=%h wrap=%b period=%0d step=%0d, want 01 1 31 0", q5, w5, pr5, sc5);
    end
    checks++;
    if (seen !== 32'hFFFF_FFFE) begin
      fails++;
      $display("FAIL period_coverage: seen=%h want fffffffe", seen);
    end
    cyc5(0, 0, 0, 0);
    checks++;
    if (w5 !== 1'b0 || pr5 !== 5'd31) begin
      fails++;
      $display("FAIL wrap_pulse: wrap=%b period=%0d, want 0 31", w5, pr5);
    end
  endtask
  task automatic test_toggle_en;
    int wraps = 0;
    cyc5(1, 0, 0, 0);
    for (int i = 0; i < 62; i++) begin
      cyc5(0, 0, (i % 2 == 0), 0);
      wraps += int'(w5);
      checks++;
      if ({q5, w5, lk5, sc5, pr5} !== {5'(mq), mwrap, mlock, 5'(mstep), 5'(mper)}) begin
        fails++;
        $display("FAIL toggle%0d: q=%h w=%b l=%b s=%0d p=%0d, want q=%h w=%b l=%b s=%0d p=%0d",
                 i, q5, w5, lk5, sc5, pr5, mq, mwrap, mlock, mstep, mper);
      end
    end
    checks++;
    if (wraps != 1) begin
      fails++;
      $display("FAIL toggle_wraps: saw %0d wraps, want 1", wraps);
    end
  endtask
  task automatic test_lockup;
    logic [4:0] p0;
    p0 = pr5;
    cyc5(0, 1, 0, 5'b00000);
    checks++;
    if (q5 !== 5'h00 || lk5 !== 1'b0 || sc5 !== 5'd0) begin
      fails++;
      $display("FAIL lockup_load: q=%h lockup=%b step=%0d, want 00 0 0", q5, lk5, sc5);
    end
    cyc5(0, 0, 1, 0);
    checks++;
    if ({q5, lk5, w5, sc5, pr5} !== {5'h01, 1'b1, 1'b0, 5'd0, p0}) begin
      fails++;
      $display("FAIL lockup_recover: q=%h lockup=%b wrap=%b step=%0d period=%0d, want 01 1 0 0 %0d",
               q5, lk5, w5, sc5, pr5, p0);
    end
    cyc5(0, 0, 1, 0);
    checks++;
    if (lk5 !== 1'b0 || q5 !== 5'b10100) begin
      fails++;
      $display("FAIL lockup_pulse: lockup=%b q=%b, want 0 10100", lk5, q5);
    end
  endtask
  task automatic test_load_priority;
    cyc5(0, 0, 1, 0);
    cyc5(0, 1, 1, 5'b10110);
    checks++;
    if (q5 !== 5'b10110 || sc5 !== 5'd0 || w5 !== 1'b0) begin
      fails++;
      $display("FAIL load_prio: q=%b step=%0d wrap=%b, want 10110 0 0", q5, sc5, w5);
    end
    cyc5(0, 0, 1, 0);
    checks++;
    if (q5 !== 5'b01011 || sc5 !== 5'd1) begin
      fails++;
      $display("FAIL load_step: q=%b step=%0d, want 01011 1", q5, sc5);
    end
  endtask
  task automatic test_reset_mid;
    for (int i = 0; i < 40; i++) cyc5(0, 0, 1, 0);
    cyc5(1, 1, 1, 5'h1f);
    checks++;
    if ({q5, w5, lk5, sc5, pr5} !== {5'h01, 1'b0, 1'b0, 5'h00, 5'h00}) begin
      fails++;
      $display("FAIL reset_mid: q=%h w=%b l=%b s=%0d p=%0d, want 01 0 0 0 0", q5, w5, lk5, sc5, pr5);
    end
  endtask
  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      cyc5($urandom_range(0, 40) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
           5'($urandom_range(0, 31) & ($urandom_range(0, 3) == 0 ? 0 : 31)));
      checks++;
      if ({q5, w5, lk5, sc5, pr5} !== {5'(mq), mwrap, mlock, 5'(mstep), 5'(mper)} || (w5 && lk5)) begin
        fails++;
        $display("FAIL random%0d: q=%h w=%b l=%b s=%0d p=%0d, want q=%h w=%b l=%b s=%0d p=%0d",
                 i, q5, w5, lk5, sc5, pr5, mq, mwrap, mlock, mstep, mper);
      end
    end
  endtask
  task automatic test_width8;
    int m = 1;
    r8 = 1; en8 = 1; ld8 = 0; lv8 = 0;
    @(posedge clk); #1;
    r8 = 0;
    checks++;
    if (q8 !== 8'h01 || pr8 !== 8'd0) begin
      fails++;
      $display("FAIL w8_reset: q=%h period=%0d, want 01 0", q8, pr8);
    end
    for (int i = 1; i <= 255; i++) begin
      @(posedge clk); #1;
      m = galois(m, 'hB8);
      checks++;
      if (q8 !== 8'(m) || w8 !== (i == 255) || lk8 !== 1'b0) begin
        fails++;
        $display("FAIL w8_step%0d: q=%h wrap=%b lockup=%b, want q=%h wrap=%b lockup=0", i, q8, w8, lk8, m, i == 255);
      end
    end
    checks++;
    if (pr8 !== 8'd255 || sc8 !== 8'd0) begin
      fails++;
      $display("FAIL w8_period: period=%0d step=%0d, want 255 0", pr8, sc8);
    end
    en8 = 0;
  endtask
  initial begin
    r5 = 1; en5 = 0; ld5 = 0; lv5 = 0;
    r8 = 1; en8 = 0; ld8 = 0; lv8 = 0;
    test_reset;
    test_first_steps;
    test_full_period;
    test_toggle_en;
    test_lockup;
    test_load_priority;
    test_reset_mid;
    test_random;
    test_width8;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
Parametrised Galois LFSR that generalises the team's fixed 5-bit LFSR. It adds configurable width, tap mask and seed, plus clock enable, parallel load and lock-up recovery. It also provides period tracking: a wrap pulse and a measured period length. It serves as the shared pseudo-random source for scramblers, test-pattern generators and BIST in the design.

Parameters:
WIDTH, 5, state width in bits (2..32)
TAPS, 5'h14, Galois feedback mask; default is polynomial x^5+x^3+1 (maximal, period 31)
SEED, 5'h01, reset and recovery state; must be non-zero

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
en  input  1  advance LFSR one step this cycle
load  input  1  parallel load of load_val; has priority over en
load_val  input  WIDTH  value written to state on load
q  output  WIDTH  current LFSR state
wrap  output  1  one-cycle pulse: the last step returned state to SEED
lockup  output  1  one-cycle pulse: an all-zero state was detected and SEED was reinserted
step_cnt  output  WIDTH  enabled steps since last reset/load/wrap
period  output  WIDTH  length of the last completed cycle; 0 until the first wrap

Behaviour:
- Single clock domain; all outputs are registered; no combinational input-to-output paths.
- Reset (synchronous, active-high; overrides everything) gives:
  - q=SEED
  - wrap=0, lockup=0
  - step_cnt=0, period=0
- Step function: nxt = (q >> 1) ^ (q[0] ? TAPS : 0).
  - With the defaults: nxt[4]=q[0], nxt[3]=q[4], nxt[2]=q[3]^q[0], nxt[1]=q[2], nxt[0]=q[1].
- Per-cycle priority (highest first):
  1. reset
  2. load
  3. en with q==0
  4. en normal
  5. hold
- load=1:
  - q<=load_val, step_cnt<=0; wrap and lockup driven 0; period unchanged.
  - en is ignored in that cycle.
  - Loading 0 is legal; the LFSR then sits in the lock-up state.
- en=1 and q==0 (lock-up):
  - q<=SEED, lockup<=1, step_cnt<=0, wrap<=0; period unchanged.
- en=1, q!=0, nxt==SEED:
  - q<=nxt, wrap<=1, period<=step_cnt+1 (truncated to WIDTH), step_cnt<=0.
- en=1, q!=0, nxt!=SEED:
  - q<=nxt, step_cnt<=step_cnt+1 (wraps modulo 2^WIDTH), wrap<=0.
- en=0 and load=0: q, step_cnt and period hold; wrap and lockup are 0.
- wrap and lockup are never asserted in the same cycle.
  - Each is high for exactly one cycle per event.
  - Back-to-back wraps are possible only for a degenerate TAPS.
- Latency: q reflects a step or load in the cycle after the edge that samples en/load.
- Reset asserted mid-sequence restores the full reset state on the next edge, regardless of en/load.
- For a maximal TAPS, q never reaches 0 except via load; step_cnt stays below 2^WIDTH-1.
- A non-maximal TAPS is legal: period then reports the actual cycle length containing SEED.
- If a load places the state on a cycle that does not contain SEED, wrap never fires; step_cnt wraps modulo 2^WIDTH.

Test Plan:
- Reset, then en=1 for 5 cycles -> q sequence 00001,10100,01010,00101,10110,01011; wrap=0; step_cnt=5.
- From reset, en=1 for 31 cycles -> on the 31st step q=00001, wrap=1 for one cycle, period=31, step_cnt=0; all 31 non-zero values seen exactly once.
- Toggle en 1/0 alternately for 62 cycles -> q advances only on en cycles; wrap fires once after the 31st enabled step; step_cnt holds during en=0.
- load=1, load_val=00000, then en=1 -> q=00000 for one cycle, then q=00001 with lockup=1 for one cycle; step_cnt=0; period unchanged.
- load=1 and en=1 together with load_val=10110 -> q=10110 (no step applied); step_cnt=0; next en step gives q=01011.
- After 10 steps, assert reset for one cycle with en=1 -> q=00001, step_cnt=0, period=0, wrap=0, lockup=0. Repeat with WIDTH=8, TAPS=8'hB8, SEED=8'h01 -> period=255 after 255 steps.
